// File: rtl/insn_fetch_queue.sv
// Sequential instruction prefetcher with an in-order word queue and redirect/stale-response dropping.
// Optional FETCH_BYPASS_EN forwards a response straight to insn when the queue is empty.
module insn_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_addr,
    output logic [31:0] insn,
    output logic        insn_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   pf_addr_q, pf_addr_d;
    logic [31:0]   resp_addr_q, resp_addr_d;

    logic head_hit;
    logic bypass_hit;
    logic resp_ok;
    logic resp_keep;
    logic in_window;
    logic do_grant;
    logic do_write;

    // An empty window (resp_addr == pf_addr) still accepts fetch_addr == resp_addr,
    // since the next word issued is exactly that address.
    always_comb begin
        resp_ok   = mem_rvalid && (out_cnt_q != '0);
        resp_keep = resp_ok && (drop_cnt_q == '0);
        head_hit  = (state_q == FETCH) && (count_q != '0) && (addr_q[rd_ptr_q] == fetch_addr);
        in_window = ((fetch_addr - resp_addr_q) < (pf_addr_q - resp_addr_q)) ||
                    (fetch_addr == resp_addr_q);
        mem_req   = (state_q == FETCH) && (({1'b0, count_q} + {1'b0, out_cnt_q}) < DEPTH_W);
        mem_addr  = pf_addr_q;
        do_grant  = mem_req && mem_gnt;
    end

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = (state_q == FETCH) && (count_q == '0) && resp_keep &&
                        (resp_addr_q == fetch_addr);
    assign insn       = bypass_hit ? mem_rdata : (head_hit ? data_q[rd_ptr_q] : NOP_WORD);
`else
    assign bypass_hit = 1'b0;
    assign insn       = head_hit ? data_q[rd_ptr_q] : NOP_WORD;
`endif

    assign insn_valid = head_hit || bypass_hit;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_cnt_d   = out_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        pf_addr_d   = pf_addr_q;
        resp_addr_d = resp_addr_q;
        do_write    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                if (!insn_valid && ((count_q != '0) || !in_window)) begin
                    state_d = REDIRECT;
                end
                if (do_grant) begin
                    pf_addr_d = pf_addr_q + 32'd1;
                end
                if (resp_ok) begin
                    if (drop_cnt_q != '0) begin
                        drop_cnt_d = drop_cnt_q - CW'(1);
                    end else begin
                        resp_addr_d = resp_addr_q + 32'd1;
                        do_write    = !bypass_hit;
                    end
                end
                if (do_write) begin
                    addr_d[wr_ptr_q] = resp_addr_q;
                    data_d[wr_ptr_q] = mem_rdata;
                    wr_ptr_d         = wr_ptr_q + PW'(1);
                end
                if (head_hit) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                count_d   = count_q + CW'(do_write) - CW'(head_hit);
                out_cnt_d = out_cnt_q + CW'(do_grant) - CW'(resp_ok);
            end

            // Everything still outstanding after this cycle belongs to the old stream.
            REDIRECT: begin
                state_d     = FETCH;
                out_cnt_d   = out_cnt_q - CW'(resp_ok);
                drop_cnt_d  = out_cnt_q - CW'(resp_ok);
                count_d     = '0;
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                pf_addr_d   = fetch_addr;
                resp_addr_d = fetch_addr;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '{default: '0};
            data_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            pf_addr_q   <= '0;
            resp_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_cnt_q   <= out_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            pf_addr_q   <= pf_addr_d;
            resp_addr_q <= resp_addr_d;
        end
    end

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed bench for insn_fetch_queue: a per-cycle vector table for startup and streaming,
// then hand-written sequences for backpressure, full, redirect, response-cycle and mid-run reset.
module tb_insn_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_addr;
    logic [31:0] insn;
    logic        insn_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    insn_fetch_queue #(
        .DEPTH   (DEPTH),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_addr(fetch_addr),
        .insn      (insn),
        .insn_valid(insn_valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] fa;
        logic        gnt;
        logic        req;
        logic [31:0] maddr;
        logic        valid;
        logic [31:0] insn;
    } vec_t;

    pend_t       pend[$];
    vec_t        vecs[19];
    int          cyc;
    int          lat;
    int          total;
    int          bad;
    int          fullSeen;
    logic [31:0] coreFa;
    logic        gntEn;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        bad++;
        $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [31:0] fa, input logic gnt);
        fetch_addr = fa;
        mem_gnt    = gnt;
    endtask

    // Memory: in-order responses, each due 'lat' cycles after its grant cycle.
    task automatic driveMem();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memWord(pend[0].a);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    // Called at a negedge: records this cycle's handshakes, moves to posedge+1.
    task automatic advance();
        logic        issued;
        logic [31:0] ia;
        logic        rsp;
        issued = mem_req && mem_gnt;
        ia     = mem_addr;
        rsp    = mem_rvalid;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp) void'(pend.pop_front());
        if (issued) pend.push_back('{ia, cyc - 1 + lat});
        driveMem();
    endtask

    task automatic runStream(input logic [31:0] target, input int budget);
        int n;
        n = 0;
        while (coreFa != target && n < budget) begin
            applyStimulus(coreFa, gntEn);
            @(negedge clk);
            checkOutput("outstanding_le_depth", {31'b0, (pend.size() <= DEPTH)}, 32'd1);
            if (pend.size() == DEPTH) begin
                fullSeen++;
                checkOutput("req_low_when_full", {31'b0, mem_req}, 32'd0);
            end
            if (insn_valid) begin
                checkOutput("stream_insn", insn, memWord(coreFa));
                coreFa = coreFa + 32'd1;
            end
            advance();
            n++;
        end
        if (coreFa != target) failNow("stream_timeout", coreFa, target);
    endtask

    task automatic waitIssue(input logic [31:0] exp, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            applyStimulus(coreFa, gntEn);
            @(negedge clk);
            if (mem_req && mem_gnt) begin
                seen = 1'b1;
                checkOutput("issue_addr", mem_addr, exp);
            end
            advance();
        end
        if (!seen) failNow("issue_timeout", 32'd0, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        int nDrain;

        rst_n      = 1'b0;
        fetch_addr = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        cyc        = 0;
        lat        = 1;
        gntEn      = 1'b1;
        total      = 0;
        bad        = 0;
        fullSeen   = 0;

        // Cycle k is the k-th clock period after reset release; grant is immediate and
        // data returns the cycle after the grant.
        vecs[0] = '{32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[1] = '{32'd0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
`ifdef FETCH_BYPASS_EN
        for (int k = 0; k < 17; k++)
            vecs[2 + k] = '{32'(k), 1'b1, 1'b1, 32'(k + 1), 1'b1, memWord(32'(k))};
`else
        vecs[2] = '{32'd0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0};
        for (int k = 0; k < 16; k++)
            vecs[3 + k] = '{32'(k), 1'b1, 1'b1, 32'(k + 2), 1'b1, memWord(32'(k))};
`endif

        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_valid", {31'b0, insn_valid}, 32'd0);
        checkOutput("rst_insn", insn, 32'd0);
        checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        advance();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].fa, vecs[i].gnt);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
            checkOutput($sformatf("vec%0d_addr", i), mem_addr, vecs[i].maddr);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, insn_valid}, {31'b0, vecs[i].valid});
            checkOutput($sformatf("vec%0d_insn", i), insn, vecs[i].insn);
            advance();
        end
        coreFa = vecs[18].fa + 32'd1;

        // No grants for 10 cycles: the core drains what is buffered, then waits without a redirect.
        nDrain = BYP ? 1 : 2;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(coreFa, 1'b0);
            @(negedge clk);
            checkOutput("bp_req", {31'b0, mem_req}, 32'd1);
            checkOutput("bp_addr", mem_addr, 32'd18);
            checkOutput("bp_valid", {31'b0, insn_valid}, {31'b0, (i < nDrain)});
            if (insn_valid) begin
                checkOutput("bp_insn", insn, memWord(coreFa));
                coreFa = coreFa + 32'd1;
            end
            advance();
        end
        gntEn = 1'b1;
        runStream(32'd30, 40);

        lat = 6;
        runStream(32'd50, 150);
        checkOutput("full_reached", {31'b0, (fullSeen > 0)}, 32'd1);

        // Taken branch to 20 with responses still in flight.
        lat = 3;
        runStream(32'd56, 60);
        coreFa = 32'd20;
        applyStimulus(coreFa, 1'b1);
        @(negedge clk);
        checkOutput("jump_valid", {31'b0, insn_valid}, 32'd0);
        checkOutput("jump_inflight", {31'b0, ((pend.size() + int'(mem_req && mem_gnt)) > 0)}, 32'd1);
        advance();
        applyStimulus(coreFa, 1'b1);
        @(negedge clk);
        checkOutput("redirect_req", {31'b0, mem_req}, 32'd0);
        checkOutput("redirect_valid", {31'b0, insn_valid}, 32'd0);
        advance();
        waitIssue(32'd20, 10);
        runStream(32'd26, 40);

        // Branch to 8: in the cycle the word for 8 returns, insn_valid reflects bypass.
        lat = 1;
        coreFa = 32'd8;
        applyStimulus(coreFa, 1'b1);
        @(negedge clk);
        checkOutput("jump8_valid", {31'b0, insn_valid}, 32'd0);
        advance();
        applyStimulus(coreFa, 1'b1);
        @(negedge clk);
        checkOutput("redirect8_req", {31'b0, mem_req}, 32'd0);
        advance();
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            applyStimulus(coreFa, 1'b1);
            @(negedge clk);
            if (mem_rvalid && pend.size() > 0 && pend[0].a == 32'd8) begin
                found = 1'b1;
                checkOutput("resp8_valid", {31'b0, insn_valid}, {31'b0, BYP});
                if (insn_valid) begin
                    checkOutput("resp8_insn", insn, memWord(32'd8));
                    coreFa = coreFa + 32'd1;
                end
            end
            advance();
        end
        if (!found) failNow("resp8_timeout", 32'd0, 32'd8);
        runStream(32'd12, 30);

        // Reset with responses outstanding; they land while out_cnt is zero.
        lat = 3;
        runStream(32'd18, 30);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'b0, insn_valid}, 32'd0);
        checkOutput("midrst_insn", insn, 32'd0);
        checkOutput("midrst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("midrst_addr", mem_addr, 32'd0);
        @(negedge clk);
        advance();
        @(negedge clk);
        checkOutput("midrst_req_hold", {31'b0, mem_req}, 32'd0);
        advance();
        rst_n  = 1'b1;
        coreFa = 32'd0;
        waitIssue(32'd0, 6);
        runStream(32'd6, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
